// File: rtl/fp_addsub_arbiter_if.sv
// Bundle of requester, shared fp add/sub unit and response signals for fp_addsub_arbiter.
// The master side is the environment (requesters plus the fp unit); the slave side is the arbiter.
interface fp_addsub_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*32-1:0] req_num1;
  logic [N_REQ*32-1:0] req_num2;
  logic [N_REQ-1:0]    req_op;
  logic [31:0]         fu_num1;
  logic [31:0]         fu_num2;
  logic                fu_op;
  logic [31:0]         fu_s;
  logic                resp_valid;
  logic [IDW-1:0]      resp_id;
  logic [31:0]         resp_data;
  logic                busy;

  modport master (
    output req_valid, req_num1, req_num2, req_op, fu_s,
    input  req_ready, fu_num1, fu_num2, fu_op, resp_valid, resp_id, resp_data, busy
  );

  modport slave (
    input  req_valid, req_num1, req_num2, req_op, fu_s,
    output req_ready, fu_num1, fu_num2, fu_op, resp_valid, resp_id, resp_data, busy
  );
endinterface

// File: rtl/fp_addsub_arbiter.sv
// Round-robin front end sharing one pipelined fp add/sub unit among N_REQ requesters.
// A tag pipeline matched to the unit latency steers each result back to its owner.
module fp_addsub_arbiter #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 2,
  parameter int IDW     = $clog2(N_REQ)
) (
  input logic                clk,
  input logic                rst,
  fp_addsub_arbiter_if.slave bus
);

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   win;
  logic             win_vld;
  logic             accept;
  logic [N_REQ-1:0] ready_oh;
  logic [31:0]      fu_num1_q;
  logic [31:0]      fu_num2_q;
  logic             fu_op_q;
  logic [LATENCY:0] tag_v;
  logic [IDW-1:0]   tag_id [LATENCY+1];

  // Scan from farthest to nearest so the first requester at or after rr_ptr wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        win     = IDW'((int'(rr_ptr) + k) % N_REQ);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    ready_oh = '0;
    if (win_vld && !rst) ready_oh[win] = 1'b1;
  end

  assign accept        = win_vld & ~rst;
  assign bus.req_ready = ready_oh;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      fu_num1_q <= '0;
      fu_num2_q <= '0;
      fu_op_q   <= 1'b0;
      tag_v     <= '0;
      for (int s = 0; s <= LATENCY; s++) tag_id[s] <= '0;
    end else begin
      if (accept) begin
        rr_ptr    <= (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
        fu_num1_q <= bus.req_num1[int'(win)*32 +: 32];
        fu_num2_q <= bus.req_num2[int'(win)*32 +: 32];
        fu_op_q   <= bus.req_op[win];
      end
      tag_v[0]  <= accept;
      tag_id[0] <= win;
      for (int s = 1; s <= LATENCY; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  assign bus.fu_num1    = fu_num1_q;
  assign bus.fu_num2    = fu_num2_q;
  assign bus.fu_op      = fu_op_q;
  assign bus.resp_valid = tag_v[LATENCY];
  assign bus.resp_id    = tag_v[LATENCY] ? tag_id[LATENCY] : '0;
  assign bus.resp_data  = bus.fu_s;
  assign bus.busy       = |tag_v;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Bench for fp_addsub_arbiter: models the shared fp unit as a LATENCY-deep pipeline and checks
// grants, operand routing and responses against a queue-based reference of accepted requests.
module tb_fp_addsub_arbiter;
  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   m_ptr    = 0;
  logic [31:0] m_fu1 = '0;
  logic [31:0] m_fu2 = '0;
  logic        m_fuop = 1'b0;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } rsp_t;
  rsp_t m_q[$];

  logic [31:0] fu_pipe [LAT];

  always #5 clk = ~clk;

  fp_addsub_arbiter_if #(.N_REQ(N), .IDW(IDW)) bus ();

  fp_addsub_arbiter #(.N_REQ(N), .LATENCY(LAT), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in fp unit: exact results for the reference vectors, a scrambling function otherwise.
  function automatic logic [31:0] fu_fn(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (op && a == 32'h4121C28F && b == 32'h3F8E147B) return 32'h41100000;
    if (op && a == 32'hC121C28F && b == 32'h3F8E147B) return 32'hC133851E;
    return (a + {b[15:0], b[31:16]}) ^ {op, 31'h2A5C3E19};
  endfunction

  always @(posedge clk) begin
    fu_pipe[0] <= fu_fn(bus.fu_num1, bus.fu_num2, bus.fu_op);
    for (int i = 1; i < LAT; i++) fu_pipe[i] <= fu_pipe[i-1];
  end
  assign bus.fu_s = fu_pipe[LAT-1];

  function automatic int model_winner();
    for (int k = 0; k < N; k++)
      if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int w;
    r = '0;
    w = model_winner();
    if (!rst && w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  // One clock edge; the reference model advances alongside the DUT.
  task automatic tick();
    int   w;
    rsp_t r;
    w = rst ? -1 : model_winner();
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_ptr = 0;
      m_q.delete();
      m_fu1 = '0;
      m_fu2 = '0;
      m_fuop = 1'b0;
    end else if (w >= 0) begin
      m_ptr  = (w + 1) % N;
      m_fu1  = bus.req_num1[w*32 +: 32];
      m_fu2  = bus.req_num2[w*32 +: 32];
      m_fuop = bus.req_op[w];
      r.due  = cyc + LAT;
      r.id   = w;
      r.data = fu_fn(m_fu1, m_fu2, m_fuop);
      m_q.push_back(r);
    end
    while (m_q.size() > 0 && m_q[0].due < cyc) void'(m_q.pop_front());
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
    bus.req_num1[i*32 +: 32] = a;
    bus.req_num2[i*32 +: 32] = b;
    bus.req_op[i]            = op;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    rand_ops();
    #1;
    n_checks++;
    if (bus.req_ready !== '0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
    tick();
    tick();
    n_checks++;
    if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    n_checks++;
    if (bus.resp_id !== '0) begin n_fail++; $display("FAIL reset_resp_id got=%0d exp=0", bus.resp_id); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++;
    if (bus.fu_num1 !== 32'h0 || bus.fu_num2 !== 32'h0 || bus.fu_op !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fu got=%h/%h/%b exp=0/0/0", bus.fu_num1, bus.fu_num2, bus.fu_op);
    end
    rst = 1'b0;
    bus.req_valid = '0;
    tick();
    n_checks++;
    if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle got rv=%b busy=%b exp rv=0 busy=0", bus.resp_valid, bus.busy);
    end
  endtask

  task automatic test_vectors();
    logic [31:0]  va   [2] = '{32'h4121C28F, 32'hC121C28F};
    logic [31:0]  vexp [2] = '{32'h41100000, 32'hC133851E};
    int           vid  [2] = '{1, 2};
    logic [N-1:0] exp_r;
    for (int t = 0; t < 2; t++) begin
      bus.req_valid = '0;
      bus.req_valid[vid[t]] = 1'b1;
      set_req(vid[t], va[t], 32'h3F8E147B, 1'b1);
      #1;
      exp_r = '0;
      exp_r[vid[t]] = 1'b1;
      n_checks++;
      if (bus.req_ready !== exp_r) begin n_fail++; $display("FAIL vec%0d_ready got=%b exp=%b", t, bus.req_ready, exp_r); end
      tick();
      bus.req_valid = '0;
      n_checks++;
      if (bus.fu_num1 !== va[t] || bus.fu_num2 !== 32'h3F8E147B || bus.fu_op !== 1'b1) begin
        n_fail++;
        $display("FAIL vec%0d_fu got=%h/%h/%b exp=%h/3f8e147b/1", t, bus.fu_num1, bus.fu_num2, bus.fu_op, va[t]);
      end
      for (int e = 1; e <= LAT + 3; e++) begin
        n_checks++;
        if (bus.resp_valid !== (e == LAT + 1)) begin
          n_fail++;
          $display("FAIL vec%0d_resp_valid edge%0d got=%b exp=%b", t, e, bus.resp_valid, (e == LAT + 1));
        end
        if (e == LAT + 1) begin
          n_checks++;
          if (bus.resp_id !== IDW'(vid[t]) || bus.resp_data !== vexp[t]) begin
            n_fail++;
            $display("FAIL vec%0d_resp got id=%0d data=%h exp id=%0d data=%h", t, bus.resp_id, bus.resp_data, vid[t], vexp[t]);
          end
        end
        n_checks++;
        if (bus.busy !== (e <= LAT + 1)) begin
          n_fail++;
          $display("FAIL vec%0d_busy edge%0d got=%b exp=%b", t, e, bus.busy, (e <= LAT + 1));
        end
        tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    int           got_id  [$];
    int           got_cyc [$];
    logic [31:0]  got_d   [$];
    logic [31:0]  exp_d   [$];
    logic [N-1:0] exp_r;
    int           busy_low;
    busy_low = 0;
    pulse_reset();
    bus.req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      rand_ops();
      exp_d.push_back(fu_fn(bus.req_num1[(c%N)*32 +: 32], bus.req_num2[(c%N)*32 +: 32], bus.req_op[c%N]));
      #1;
      exp_r = '0;
      exp_r[c%N] = 1'b1;
      n_checks++;
      if (bus.req_ready !== exp_r) begin n_fail++; $display("FAIL b2b_grant%0d got=%b exp=%b", c, bus.req_ready, exp_r); end
      tick();
      if (bus.busy !== 1'b1) busy_low++;
      if (bus.resp_valid === 1'b1) begin got_id.push_back(int'(bus.resp_id)); got_d.push_back(bus.resp_data); got_cyc.push_back(cyc); end
    end
    bus.req_valid = '0;
    for (int c = 0; c < LAT + 2; c++) begin
      tick();
      if (got_id.size() < 8 && bus.busy !== 1'b1) busy_low++;
      if (bus.resp_valid === 1'b1) begin got_id.push_back(int'(bus.resp_id)); got_d.push_back(bus.resp_data); got_cyc.push_back(cyc); end
    end
    n_checks++;
    if (busy_low != 0) begin n_fail++; $display("FAIL b2b_busy low_cycles got=%0d exp=0", busy_low); end
    n_checks++;
    if (got_id.size() != 8) begin
      n_fail++;
      $display("FAIL b2b_resp_count got=%0d exp=8", got_id.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if (got_id[k] != k % N || got_d[k] !== exp_d[k] || got_cyc[k] != got_cyc[0] + k) begin
          n_fail++;
          $display("FAIL b2b_resp%0d got id=%0d data=%h cyc=%0d exp id=%0d data=%h cyc=%0d",
                   k, got_id[k], got_d[k], got_cyc[k], k % N, exp_d[k], got_cyc[0] + k);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] exp_seq [3] = '{4'b1000, 4'b0001, 4'b1000};
    pulse_reset();
    rand_ops();
    bus.req_valid = 4'b0001;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_first got=%b exp=0001", bus.req_ready); end
    tick();
    bus.req_valid = 4'b1001;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (bus.req_ready !== exp_seq[c]) begin n_fail++; $display("FAIL wrap_grant%0d got=%b exp=%b", c, bus.req_ready, exp_seq[c]); end
      tick();
    end
    bus.req_valid = '0;
    for (int c = 0; c < LAT + 2; c++) tick();
  endtask

  task automatic test_reset_inflight();
    pulse_reset();
    rand_ops();
    bus.req_valid = '1;
    for (int c = 0; c < 3; c++) tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== '0) begin n_fail++; $display("FAIL inflight_rst_ready got=%b exp=0000", bus.req_ready); end
    tick();
    rst = 1'b0;
    bus.req_valid = '0;
    for (int e = 0; e < LAT + 3; e++) begin
      n_checks++;
      if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL inflight_discard edge%0d got rv=%b busy=%b exp rv=0 busy=0", e, bus.resp_valid, bus.busy);
      end
      tick();
    end
    bus.req_valid = 4'b1010;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL inflight_next_grant got=%b exp=0010", bus.req_ready); end
    tick();
    bus.req_valid = '0;
  endtask

  task automatic test_idle();
    logic [31:0]  h1, h2;
    logic         hop;
    int           ptr0;
    logic [N-1:0] exp_r;
    bus.req_valid = '0;
    for (int c = 0; c < LAT + 2; c++) tick();
    h1 = m_fu1;
    h2 = m_fu2;
    hop = m_fuop;
    ptr0 = m_ptr;
    for (int c = 0; c < 10; c++) begin
      rand_ops();
      #1;
      n_checks++;
      if (bus.req_ready !== '0 || bus.resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle%0d got ready=%b rv=%b exp ready=0000 rv=0", c, bus.req_ready, bus.resp_valid);
      end
      n_checks++;
      if (bus.fu_num1 !== h1 || bus.fu_num2 !== h2 || bus.fu_op !== hop) begin
        n_fail++;
        $display("FAIL idle_fu_hold%0d got=%h/%h/%b exp=%h/%h/%b", c, bus.fu_num1, bus.fu_num2, bus.fu_op, h1, h2, hop);
      end
      tick();
    end
    bus.req_valid = '1;
    #1;
    exp_r = '0;
    exp_r[ptr0] = 1'b1;
    n_checks++;
    if (bus.req_ready !== exp_r) begin n_fail++; $display("FAIL idle_ptr_hold got=%b exp=%b", bus.req_ready, exp_r); end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0]   exp_r;
    logic           exp_rv;
    logic [IDW-1:0] exp_id;
    logic [31:0]    exp_data;
    for (int c = 0; c < 300; c++) begin
      bus.req_valid = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      rand_ops();
      rst = ($urandom_range(0, 39) == 0);
      #1;
      exp_r = model_ready();
      n_checks++;
      if (bus.req_ready !== exp_r) begin n_fail++; $display("FAIL rand%0d_ready got=%b exp=%b", c, bus.req_ready, exp_r); end
      tick();
      exp_rv   = (m_q.size() > 0 && m_q[0].due == cyc);
      exp_id   = exp_rv ? IDW'(m_q[0].id) : '0;
      exp_data = exp_rv ? m_q[0].data : 32'h0;
      n_checks++;
      if (bus.resp_valid !== exp_rv || bus.resp_id !== exp_id || bus.busy !== (m_q.size() > 0)) begin
        n_fail++;
        $display("FAIL rand%0d_resp got rv=%b id=%0d busy=%b exp rv=%b id=%0d busy=%b",
                 c, bus.resp_valid, bus.resp_id, bus.busy, exp_rv, exp_id, (m_q.size() > 0));
      end
      if (exp_rv) begin
        n_checks++;
        if (bus.resp_data !== exp_data) begin n_fail++; $display("FAIL rand%0d_data got=%h exp=%h", c, bus.resp_data, exp_data); end
      end
      n_checks++;
      if (bus.fu_num1 !== m_fu1 || bus.fu_num2 !== m_fu2 || bus.fu_op !== m_fuop) begin
        n_fail++;
        $display("FAIL rand%0d_fu got=%h/%h/%b exp=%h/%h/%b", c, bus.fu_num1, bus.fu_num2, bus.fu_op, m_fu1, m_fu2, m_fuop);
      end
    end
    rst = 1'b0;
    bus.req_valid = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_num1 = '0;
    bus.req_num2 = '0;
    bus.req_op = '0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_wrap();
    test_reset_inflight();
    test_idle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_addsub_arbiter.md
FP_ADDSUB_ARBITER -- requirements
Module: fp_addsub_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one fp_add_sub unit (2..8).
REQ-002 Parameter LATENCY, default 2, cycles from fu_num1/fu_num2/fu_op update to the matching fu_s being valid (0..8).
REQ-003 Parameter IDW, default $clog2(N_REQ), width of resp_id.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  N_REQ  per-requester operation request.
REQ-007 req_ready  out  N_REQ  per-requester accept, one-hot or zero.
REQ-008 req_num1  in  N_REQ*32  IEEE-754 single operand A; slice i belongs to requester i.
REQ-009 req_num2  in  N_REQ*32  IEEE-754 single operand B; slice i.
REQ-010 req_op  in  N_REQ  0 = add, 1 = subtract (A - B).
REQ-011 fu_num1  out  32  operand A to the shared unit.
REQ-012 fu_num2  out  32  operand B to the shared unit.
REQ-013 fu_op  out  1  op to the shared unit.
REQ-014 fu_s  in  32  result from the shared unit.
REQ-015 resp_valid  out  1  result strobe, one cycle per accepted request.
REQ-016 resp_id  out  IDW  index of the requester owning resp_data.
REQ-017 resp_data  out  32  result word, equal to fu_s at the cycle resp_valid is high.
REQ-018 busy  out  1  high while any accepted request has not yet been returned.

Function
REQ-019 Arbitration SHALL be round-robin: search starts at pointer rr_ptr, wraps modulo N_REQ, first requester with req_valid high wins.
REQ-020 req_ready SHALL be combinational from req_valid and rr_ptr: one-hot at the winner, all zero if no req_valid or rst high.
REQ-021 A request is accepted at a rising edge where req_valid[i] and req_ready[i] are both high; at most one acceptance per cycle.
REQ-022 On acceptance, rr_ptr SHALL become (winner + 1) mod N_REQ; with no acceptance rr_ptr holds.
REQ-023 On acceptance, fu_num1/fu_num2/fu_op SHALL register the winner's slices; otherwise they hold their previous values.
REQ-024 A tag pipeline (valid bit + requester index) of depth LATENCY+1 SHALL track each acceptance; one entry per cycle, no stalls.
REQ-025 resp_valid SHALL go high exactly LATENCY+1 cycles after the acceptance edge, with resp_id = accepted requester and resp_data = fu_s.
REQ-026 Responses have no backpressure; requesters SHALL be able to take resp_valid every cycle.
REQ-027 Throughput SHALL be one accepted request per cycle sustained; back-to-back results from different requesters SHALL appear in acceptance order.
REQ-028 A requester holding req_valid high continuously with all others also requesting SHALL be granted exactly once every N_REQ cycles.
REQ-029 Operand fields are passed through unmodified; no FP arithmetic inside this block.
REQ-030 busy SHALL be the OR of all tag-pipeline valid bits.
REQ-031 With LATENCY = 0, resp_valid SHALL assert the cycle after acceptance (registered-inputs path only).
REQ-032 rr_ptr wrap: winner N_REQ-1 SHALL set rr_ptr to 0.

Reset
REQ-033 With rst high at a rising edge: rr_ptr = 0, all tag-pipeline entries invalid, fu_num1 = fu_num2 = 0, fu_op = 0.
REQ-034 During and immediately after reset: resp_valid = 0, resp_id = 0, resp_data = fu_s (don't-care while resp_valid is low), busy = 0, req_ready = 0 while rst is high.
REQ-035 Reset mid-operation SHALL discard all in-flight requests; no resp_valid for them after rst deasserts.
REQ-036 The first acceptance after reset SHALL go to the lowest-index requesting input.

Verification
REQ-037 Single request, LATENCY=2: req 1 issues 0x4121C28F - 0x3F8E147B (op=1) -> req_ready[1] same cycle; resp_valid 3 cycles later, resp_id=1, resp_data=0x41100000.
REQ-038 Subtract of negatives: req 2 issues 0xC121C28F - 0x3F8E147B (op=1) -> resp_id=2, resp_data=0xC133851E after LATENCY+1 cycles.
REQ-039 All 4 requesters hold req_valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; 8 responses in the same order, one per cycle, busy high throughout.
REQ-040 Requesters 0 and 3 only, rr_ptr=1 -> grant 3 then 0 then 3, confirming wrap-around.
REQ-041 Accept 3 requests, assert rst for 1 cycle while all are in flight -> no resp_valid afterwards, busy=0, next grant goes to lowest-index requester.
REQ-042 Idle bus (no req_valid for 10 cycles) -> req_ready=0, resp_valid=0, fu_* held at last values, rr_ptr unchanged.
